// File: rtl/ex_lsu_pkg.sv
// ex_lsu_pkg: RV32I load/store opcodes, funct3 codes and LSU FSM states.
// Shared by ex_lsu and its lane-alignment helper.
package ex_lsu_pkg;

    localparam logic [6:0] INST_TYPE_L = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S = 7'b0100011;

    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;

    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_t;

endpackage

// File: rtl/ex_lsu_if.sv
// ex_lsu_if: data-bus request/grant/response bundle.
// master = load/store unit, slave = memory side.
interface ex_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store strobe/data replication and load byte/half
// select with sign or zero extension. Purely combinational.
module lsu_lane_align
    import ex_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_src,
    output logic [3:0]  st_strb,
    output logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_src,
    output logic [31:0] ld_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        st_strb = 4'b1111;
        st_data = st_src;
        case (st_funct3)
            INST_SB: begin
                st_strb = 4'b0001 << st_off;
                st_data = {4{st_src[7:0]}};
            end
            INST_SH: begin
                st_strb = st_off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{st_src[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    b = ld_src[7:0];
            2'd1:    b = ld_src[15:8];
            2'd2:    b = ld_src[23:16];
            default: b = ld_src[31:24];
        endcase
        h = ld_off[1] ? ld_src[31:16] : ld_src[15:0];
        ld_data = ld_src;
        case (ld_funct3)
            INST_LB:  ld_data = {{24{b[7]}}, b};
            INST_LH:  ld_data = {{16{h[15]}}, h};
            INST_LBU: ld_data = {24'd0, b};
            INST_LHU: ld_data = {16'd0, h};
            default:  ;
        endcase
    end

endmodule

// File: rtl/ex_lsu.sv
// ex_lsu: execute-stage load/store unit, one bus access per op with timeout.
// `define MISALIGN_TRAP_EN traps misaligned H/W accesses instead of aligning.
module ex_lsu
    import ex_lsu_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [31:0] reg2_rdata_i,
    output logic        hold_req_o,
    ex_lsu_if.master    mem,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        bus_err_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_o,
    output logic [31:0] bad_addr_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LIM =
        CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    lsu_state_t state, state_nxt;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_ld, is_st, valid, trap, tmo;
    logic [31:0]      ea, ea_al;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic             we_q, req_q, reg_we_q, err_q;
    logic [4:0]       rd_q;
    logic [1:0]       off_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [3:0]       wstrb_q;
    logic [3:0]       st_strb;
    logic [31:0]      st_data, ld_data;
    logic             unused_inst;

    assign opcode      = inst_i[6:0];
    assign funct3      = inst_i[14:12];
    assign unused_inst = ^inst_i[31:15];
    assign ea          = op1_i + op2_i;

    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        if (opcode == INST_TYPE_L)
            is_ld = funct3 inside {INST_LB, INST_LH, INST_LW,
                                   INST_LBU, INST_LHU};
        if (opcode == INST_TYPE_S)
            is_st = funct3 inside {INST_SB, INST_SH, INST_SW};
    end
    assign valid = is_ld | is_st;

    always_comb begin
        ea_al = ea;
        case (funct3[1:0])
            2'b01:   ea_al = {ea[31:1], 1'b0};
            2'b10:   ea_al = {ea[31:2], 2'b00};
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic        mis_q;
    logic [31:0] bad_q;
    assign trap = valid &&
        ((funct3[1:0] == 2'b01 && ea[0]) ||
         (funct3[1:0] == 2'b10 && ea[1:0] != 2'b00));
    assign misalign_o = mis_q;
    assign bad_addr_o = bad_q;
`else
    assign trap = 1'b0;
`endif

    // Timeout fires on the cycle the counter would step to WAIT_MAX
    assign tmo = (WAIT_MAX > 0) && (cnt == CNT_LIM);

    lsu_lane_align u_align (
        .st_funct3 (funct3),
        .st_off    (ea[1:0]),
        .st_src    (reg2_rdata_i),
        .st_strb   (st_strb),
        .st_data   (st_data),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_src    (mem.rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        hold_req_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid && !rst) begin
                    hold_req_o = 1'b1;
                    state_nxt  = trap ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                hold_req_o = 1'b1;
                if (mem.gnt)  state_nxt = S_WAIT;
                else if (tmo) state_nxt = S_DONE;
            end
            S_WAIT: begin
                hold_req_o = 1'b1;
                if (mem.rvalid || tmo) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            f3_q     <= '0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            off_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            reg_we_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
            bad_q    <= '0;
`endif
        end else begin
            reg_we_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        f3_q    <= funct3;
                        we_q    <= is_st;
                        rd_q    <= inst_i[11:7];
                        off_q   <= ea[1:0];
                        addr_q  <= ea_al;
                        wdata_q <= st_data;
                        wstrb_q <= is_st ? st_strb : 4'b0000;
                        cnt     <= '0;
`ifdef MISALIGN_TRAP_EN
                        bad_q   <= ea;
                        mis_q   <= trap;
`endif
                        req_q   <= !trap;
                    end
                end
                S_REQ: begin
                    if (mem.gnt) begin
                        req_q <= 1'b0;
                        cnt   <= '0;
                    end else if (tmo) begin
                        req_q <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem.rvalid) begin
                        if (!we_q) rdata_q <= ld_data;
                        reg_we_q <= !we_q && (rd_q != 5'd0);
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign mem.req     = req_q;
    assign mem.we      = we_q;
    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
    assign mem.wstrb   = wstrb_q;
    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = rd_q;
    assign reg_wdata_o = rdata_q;
    assign bus_err_o   = err_q;

endmodule
